// File: rtl/mips_dmem_bridge.sv
// Bridges the single-cycle MIPS core data-memory port onto a valid/ready data bus.
// One bus transaction per core access; stalls the core until the access completes or times out.
module mips_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             wen_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drain_pending;
    logic             err_q;

    logic             access;
    logic             in_req;
    logic             in_resp;
    logic             resp_beat;
    logic             resp_take;
    logic             cnt_at_last;
    logic             timeout_hit;

    assign access      = cpu_mem_read | cpu_mem_write;
    assign in_req      = (state == REQ);
    assign in_resp     = (state == RESP);
    assign resp_beat   = in_resp & mem_resp_valid;
    assign resp_take   = resp_beat & ~drain_pending;
    assign cnt_at_last = (cnt_q == CNT_LAST);

    // A stale beat being drained does not count as completion, so it cannot hold off the timeout.
    assign timeout_hit = TO_EN & cnt_at_last &
                         ((in_req & ~mem_req_ready) | (in_resp & ~resp_take));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_stall      = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = access;
                if (access) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cpu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = wen_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            RESP: begin
                cpu_stall      = 1'b1;
                mem_resp_ready = 1'b1;
                if (resp_take || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wen_q         <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            drain_pending <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (state == IDLE && access) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wen_q   <= cpu_mem_write;
                wstrb_q <= cpu_mem_write ? cpu_wstrb : '0;
                cnt_q   <= '0;
            end

            // Saturating at the last count keeps a handshake on the final REQ cycle from
            // pushing the counter past the compare value.
            if ((in_req || in_resp) && !cnt_at_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (resp_beat) begin
                if (drain_pending) begin
                    drain_pending <= 1'b0;
                end else begin
                    rdata_q <= mem_rdata;
                end
            end

            if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
                if (in_resp) begin
                    drain_pending <= 1'b1;
                end
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign cpu_rdata   = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_wen     = wen_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Self-checking bench for mips_dmem_bridge: directed scenarios plus randomized accesses
// against a transaction-level model of stall length, bus fields, returned data and error flag.
module tb_mips_dmem_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata;
    logic        err_timeout;
    logic        err_clr;

    int total = 0;
    int bad   = 0;
    bit err_m = 1'b0;   // model of the sticky error flag
    bit owed  = 1'b0;   // bus still owes a late beat for an abandoned read

    mips_dmem_bridge #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_wdata     (cpu_wdata),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready),
        .mem_rdata     (mem_rdata),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access. rdly = cycles the bus holds ready low; d = RESP cycle carrying the
    // read data (0 = never answers). Called and returns at a falling edge.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int rdly, input int d, input logic [31:0] data, input bit clr);
        bit          to;
        bit          to_resp;
        bit          done;
        int          busy;
        int          exp_vc;
        int          exp_rc;
        int          d_use;
        int          stall;
        int          vc;
        int          rc;
        int          ferr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        bit          exp_err;

        to = 0; to_resp = 0; done = 0; stall = 0; vc = 0; rc = 0; ferr = 0;
        exp_rd = 32'h0; exp_rc = 0;
        d_use = d;
        if (owed && !wr && d_use == 1) d_use = 2;
        exp_strb = wr ? strb : 4'h0;

        if (rdly + 1 > T) begin
            to = 1; busy = T; exp_vc = T;
        end else if (wr) begin
            busy = rdly + 1; exp_vc = rdly + 1;
        end else if (d_use != 0 && rdly + 1 + d_use <= T) begin
            busy = rdly + 1 + d_use; exp_vc = rdly + 1; exp_rc = d_use; exp_rd = data;
        end else begin
            to = 1; to_resp = 1; busy = T; exp_vc = rdly + 1; exp_rc = T - (rdly + 1);
        end
        exp_err = to ? 1'b1 : (clr ? 1'b0 : err_m);

        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_wstrb     = strb;
        err_clr       = clr;

        for (int cyc = 0; cyc < 64; cyc++) begin
            mem_req_ready = mem_req_valid && (vc >= rdly);
            if (mem_resp_ready) begin
                rc++;
                if (owed && rc == 1) begin
                    mem_resp_valid = 1'b1; mem_rdata = 32'hAAAA0000; owed = 1'b0;
                end else if (d_use != 0 && rc == d_use) begin
                    mem_resp_valid = 1'b1; mem_rdata = data;
                end else begin
                    mem_resp_valid = 1'b0; mem_rdata = $urandom;
                end
            end else begin
                mem_resp_valid = ($urandom_range(0, 1) != 0);
                mem_rdata      = $urandom;
            end
            #1;
            if (mem_req_valid) begin
                vc++;
                if (mem_addr !== addr || mem_wen !== wr || mem_wstrb !== exp_strb ||
                    mem_wdata !== wdata) ferr++;
            end
            if (cpu_stall) stall++;
            else begin
                done = 1;
                break;
            end
            @(negedge clk);
        end

        check("done_reached", 32'(done), 32'd1);
        check("stall_cycles", 32'(stall), 32'(busy + 1));
        check("req_valid_cycles", 32'(vc), 32'(exp_vc));
        check("resp_ready_cycles", 32'(rc), 32'(exp_rc));
        check("req_fields", 32'(ferr), 32'd0);
        if (!wr) check("cpu_rdata", cpu_rdata, exp_rd);
        check("err_timeout", 32'(err_timeout), 32'(exp_err));

        if (to_resp) owed = 1'b1;
        err_m = clr ? 1'b0 : exp_err;

        @(negedge clk);
        cpu_mem_read   = 1'b0;
        cpu_mem_write  = 1'b0;
        err_clr        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_mem_read = 0; cpu_mem_write = 0; cpu_wdata = '0;
        cpu_wstrb = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; err_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk);

        run_txn(1, 0, 32'h100, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, 0);
        run_txn(0, 1, 32'h200, 32'h11223344, 4'b0011, 4, 1, 32'h0, 0);
        run_txn(1, 1, 32'h300, 32'h55667788, 4'b1111, 0, 1, 32'h0, 0);
        run_txn(1, 0, 32'h400, 32'h0, 4'h0, 0, 0, 32'h0, 0);
        run_txn(1, 0, 32'h404, 32'h0, 4'h0, 0, 2, 32'h12345678, 0);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_clr", 32'(err_timeout), 32'd0);
        err_m = 1'b0;
        @(negedge clk);

        run_txn(1, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0BAD0000, 0);
        run_txn(1, 0, 32'h4, 32'h0, 4'h0, 0, 1, 32'h0BAD0004, 0);
        run_txn(1, 0, 32'h440, 32'h0, 4'h0, 1, 0, 32'h0, 1);
        run_txn(1, 0, 32'h444, 32'h0, 4'h0, 0, 3, 32'h9ABCDEF0, 0);
        run_txn(1, 0, 32'h500, 32'h0, 4'h0, 9, 1, 32'h0, 0);

        // Reset while a read waits in RESP; error flag is set going in.
        cpu_mem_read = 1'b1; cpu_addr = 32'h600; mem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mem_resp_ready) break;
            @(negedge clk);
        end
        check("rst_mid_in_resp", 32'(mem_resp_ready), 32'd1);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mid_resp_ready", 32'(mem_resp_ready), 32'd0);
        check("rst_mid_err", 32'(err_timeout), 32'd0);
        check("rst_mid_stall_access", 32'(cpu_stall), 32'd1);
        check("rst_mid_addr", mem_addr, 32'd0);
        cpu_mem_read = 1'b0;
        #1;
        check("rst_mid_stall_idle", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0; err_m = 1'b0; owed = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            int          op;
            int          r;
            int          q;
            int          rdly;
            int          d;
            logic [31:0] addr;
            op   = $urandom_range(0, 3);
            r    = $urandom_range(0, 9);
            q    = $urandom_range(0, 9);
            rdly = (r <= 6) ? $urandom_range(0, 3) : ((r == 7) ? $urandom_range(4, 6)
                                                                : $urandom_range(8, 10));
            d    = (q <= 6) ? $urandom_range(1, 3) : ((q == 7) ? 0 : $urandom_range(4, 8));
            addr = $urandom & 32'hFFFF_FFFC;
            run_txn(op != 2, op >= 2, addr, $urandom, 4'($urandom_range(0, 15)),
                    rdly, d, $urandom, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
